// File: rtl/pemcu_dbg_trace_buf.sv
// Debug-mailbox trace capture for the PEMCU data bus: snoops writes into a mailbox
// window and queues {timestamp, slot, data} records for a host/JTAG drain port.
module pemcu_dbg_trace_buf #(
    parameter logic [15:0] BASE_ADDR = 16'hA100,
    parameter int unsigned NUM_SLOTS = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TS_W      = 16,
    parameter int unsigned POST_SLOT = 9,
    localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS),
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned REC_W    = TS_W + SLOT_W + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      memaddr,
    input  logic [7:0]       memdatao,
    input  logic             memwr,
    input  logic             memack,
    input  logic             cfg_en,
    input  logic             cfg_trig_en,
    input  logic [7:0]       cfg_trig_code,
    input  logic [7:0]       cfg_stop_code,
    input  logic             cfg_wrap,
    input  logic             cfg_clr,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [REC_W-1:0] rd_data,
    output logic [PTR_W:0]   level,
    output logic [7:0]       drop_cnt,
    output logic             overflow,
    output logic [7:0]       post_code,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                memack_q;
    logic [TS_W-1:0]     ts_q;
    logic [PTR_W:0]      wr_q, rd_q;
    logic [REC_W-1:0]    mem [DEPTH];

    logic [16:0]         offset_c;
    logic                in_win_c, event_c, slot0_c, rec_c;
    logic [SLOT_W-1:0]   slot_c;
    logic                full_c, push_c, pop_c, lose_c, write_c, adv_rd_c;

    // Bus snoop: a write counts once, on the rising edge of memack, inside the window.
    assign offset_c = {1'b0, memaddr} - {1'b0, BASE_ADDR};
    assign in_win_c = offset_c < 17'(NUM_SLOTS);
    assign slot_c   = offset_c[SLOT_W-1:0];
    assign slot0_c  = (slot_c == '0);
    assign event_c  = memack & ~memack_q & memwr & in_win_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            memack_q  <= 1'b0;
            ts_q      <= '0;
            post_code <= 8'h00;
        end else begin
            state_q  <= state_d;
            memack_q <= memack;
            ts_q     <= ts_q + TS_W'(1);
            if (event_c && slot_c == SLOT_W'(POST_SLOT)) begin
                post_code <= memdatao;
            end
        end
    end

    // Arming FSM; rec_c marks the events that become records.
    always_comb begin
        state_d = state_q;
        rec_c   = 1'b0;
        if (!cfg_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = cfg_trig_en ? ST_ARMED : ST_CAPTURE;
                ST_ARMED: begin
                    if (event_c && slot0_c && memdatao == cfg_trig_code) begin
                        rec_c   = 1'b1;
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (event_c) begin
                        rec_c = 1'b1;
                        if (slot0_c && memdatao == cfg_stop_code) begin
                            state_d = ST_STOPPED;
                        end
                    end
                end
                ST_STOPPED: state_d = ST_STOPPED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    assign state = state_q;

    // FIFO control; a full FIFO without a pop either drops or overwrites the oldest.
    assign level    = wr_q - rd_q;
    assign rd_valid = (level != '0);
    assign full_c   = (level == (PTR_W + 1)'(DEPTH));
    assign pop_c    = rd_valid & rd_ready & ~cfg_clr;
    assign push_c   = rec_c & ~cfg_clr;
    assign lose_c   = push_c & full_c & ~pop_c;
    assign write_c  = push_c & (~full_c | pop_c | cfg_wrap);
    assign adv_rd_c = pop_c | (lose_c & cfg_wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= '0;
            rd_q     <= '0;
            drop_cnt <= 8'h00;
            overflow <= 1'b0;
        end else if (cfg_clr) begin
            wr_q     <= '0;
            rd_q     <= '0;
            drop_cnt <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (write_c) begin
                wr_q <= wr_q + (PTR_W + 1)'(1);
            end
            if (adv_rd_c) begin
                rd_q <= rd_q + (PTR_W + 1)'(1);
            end
            if (lose_c) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Record storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (write_c) begin
            mem[wr_q[PTR_W-1:0]] <= {ts_q, slot_c, memdatao};
        end
    end

    assign rd_data = mem[rd_q[PTR_W-1:0]];

endmodule

// File: tb/tb_pemcu_dbg_trace_buf.sv
// Randomized and directed bench for pemcu_dbg_trace_buf, checked against a
// queue-based reference model of the trace buffer.
module tb_pemcu_dbg_trace_buf;

    localparam int DEPTH = 16;

    logic        clk, rst_n;
    logic [15:0] memaddr;
    logic [7:0]  memdatao;
    logic        memwr, memack, cfg_en, cfg_trig_en, cfg_wrap, cfg_clr, rd_ready;
    logic [7:0]  cfg_trig_code, cfg_stop_code;
    logic        rd_valid, overflow;
    logic [27:0] rd_data;
    logic [4:0]  level;
    logic [7:0]  drop_cnt, post_code;
    logic [1:0]  state;

    pemcu_dbg_trace_buf dut (
        .clk(clk), .rst_n(rst_n), .memaddr(memaddr), .memdatao(memdatao),
        .memwr(memwr), .memack(memack), .cfg_en(cfg_en), .cfg_trig_en(cfg_trig_en),
        .cfg_trig_code(cfg_trig_code), .cfg_stop_code(cfg_stop_code),
        .cfg_wrap(cfg_wrap), .cfg_clr(cfg_clr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .drop_cnt(drop_cnt),
        .overflow(overflow), .post_code(post_code), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected records live in a queue; states as small integers.
    logic [27:0] mq[$];
    int          m_ts = 0;
    bit          m_ack_q = 0;
    int          m_state = 0;
    int          m_drop = 0;
    bit          m_ovf = 0;
    logic [7:0]  m_post = 8'h00;

    task automatic model_reset();
        mq.delete();
        m_ts = 0; m_ack_q = 0; m_state = 0; m_drop = 0; m_ovf = 0; m_post = 8'h00;
    endtask

    task automatic model_step();
        int slot, nstate;
        bit ev, rec, pop, was_full;
        logic [27:0] r;
        slot   = int'(memaddr) - 'hA100;
        ev     = memack && !m_ack_q && memwr && slot >= 0 && slot < 16;
        rec    = 0;
        nstate = m_state;
        if (!cfg_en) nstate = 0;
        else if (m_state == 0) nstate = cfg_trig_en ? 1 : 2;
        else if (m_state == 1) begin
            if (ev && slot == 0 && memdatao == cfg_trig_code) begin rec = 1; nstate = 2; end
        end else if (m_state == 2) begin
            if (ev) begin
                rec = 1;
                if (slot == 0 && memdatao == cfg_stop_code) nstate = 3;
            end
        end
        r = {16'(m_ts), 4'(slot), memdatao};
        if (cfg_clr) begin
            mq.delete(); m_drop = 0; m_ovf = 0;
        end else begin
            pop      = rd_ready && mq.size() > 0;
            was_full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (rec) begin
                if (was_full && !pop) begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                    if (cfg_wrap) begin void'(mq.pop_front()); mq.push_back(r); end
                end else mq.push_back(r);
            end
        end
        if (ev && slot == 9) m_post = memdatao;
        m_state = nstate;
        m_ts    = (m_ts + 1) % 65536;
        m_ack_q = memack;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: compares every presented output against the model between edges.
    always @(negedge clk) begin
        chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("post_code", 32'(post_code), 32'(m_post));
        chk("state", 32'(state), 32'(m_state));
        if (rd_valid && mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold,
                      input bit pop, input bit clr);
        memaddr = a; memdatao = d; memwr = 1'b1; memack = 1'b1;
        rd_ready = pop; cfg_clr = clr;
        @(posedge clk); #1;
        rd_ready = 1'b0; cfg_clr = 1'b0;
        repeat (hold - 1) begin @(posedge clk); #1; end
        memack = 1'b0; memwr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        cycles(DEPTH + 2);
        rd_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; memaddr = 16'h0; memdatao = 8'h0; memwr = 0; memack = 0;
        cfg_en = 0; cfg_trig_en = 0; cfg_wrap = 0; cfg_clr = 0; rd_ready = 0;
        cfg_trig_code = 8'h02; cfg_stop_code = 8'h1E;
        cycles(3);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        rst_n = 1'b1;

        // Free capture: two records, POST slot mirrored
        cfg_en = 1'b1;
        cycles(2);
        wr(16'hA100, 8'h01, 1, 0, 0);
        wr(16'hA109, 8'h5A, 1, 0, 0);
        chk("basic_level", 32'(level), 32'd2);
        chk("basic_post", 32'(post_code), 32'h5A);
        chk("basic_head", 32'(rd_data[11:0]), 32'h001);
        drain();

        // Triggered capture and stop
        cfg_en = 1'b0; cycles(2);
        cfg_trig_en = 1'b1; cfg_en = 1'b1; cycles(2);
        chk("armed", 32'(state), 32'd1);
        wr(16'hA101, 8'h11, 1, 0, 0);
        wr(16'hA100, 8'h02, 1, 0, 0);
        wr(16'hA102, 8'h22, 1, 0, 0);
        chk("trig_state", 32'(state), 32'd2);
        chk("trig_level", 32'(level), 32'd2);
        wr(16'hA100, 8'h1E, 1, 0, 0);
        wr(16'hA101, 8'h33, 1, 0, 0);
        wr(16'hA109, 8'h77, 1, 0, 0);
        chk("stop_state", 32'(state), 32'd3);
        chk("stop_level", 32'(level), 32'd3);
        chk("stop_drop", 32'(drop_cnt), 32'd0);
        chk("stop_post", 32'(post_code), 32'h77);
        drain();

        // Stop-on-full
        cfg_en = 1'b0; cfg_trig_en = 1'b0; cycles(2);
        cfg_en = 1'b1; cycles(2);
        for (int i = 0; i < 18; i++) wr(16'hA103, 8'(i), 1, 0, 0);
        chk("nowrap_level", 32'(level), 32'd16);
        chk("nowrap_drop", 32'(drop_cnt), 32'd2);
        chk("nowrap_ovf", 32'(overflow), 32'd1);
        chk("nowrap_head", 32'(rd_data[7:0]), 32'h00);

        // Wrap mode, held memack, full push+pop, clear with push
        cfg_clr = 1'b1; cycles(1); cfg_clr = 1'b0;
        cfg_wrap = 1'b1;
        for (int i = 0; i < 18; i++) wr(16'hA103, 8'(i), 1, 0, 0);
        chk("wrap_level", 32'(level), 32'd16);
        chk("wrap_head", 32'(rd_data[7:0]), 32'h02);
        chk("wrap_drop", 32'(drop_cnt), 32'd2);
        wr(16'hA104, 8'hAB, 5, 0, 0);
        chk("held_drop", 32'(drop_cnt), 32'd3);
        wr(16'hA105, 8'hCD, 1, 1, 0);
        chk("pushpop_drop", 32'(drop_cnt), 32'd3);
        chk("pushpop_level", 32'(level), 32'd16);
        wr(16'hA106, 8'hEE, 1, 0, 1);
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_state", 32'(state), 32'd2);

        // Randomized traffic
        for (int i = 0; i < 1600; i++) begin
            if (i == 800) cfg_stop_code = 8'h02;
            memaddr = 16'hA0FE + 16'($urandom_range(0, 19));
            case ($urandom_range(0, 3))
                0:       memdatao = 8'h02;
                1:       memdatao = 8'h1E;
                default: memdatao = 8'($urandom);
            endcase
            memwr    = ($urandom_range(0, 3) != 0);
            memack   = $urandom_range(0, 1) == 1;
            rd_ready = (i < 800) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            cfg_clr  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) cfg_en = ~cfg_en;
            if ($urandom_range(0, 79) == 0) cfg_wrap = ~cfg_wrap;
            if ($urandom_range(0, 79) == 0) cfg_trig_en = ~cfg_trig_en;
            cycles(1);
        end
        memack = 0; memwr = 0; rd_ready = 0; cfg_clr = 0;

        // Async reset mid-capture
        cfg_en = 1'b1; cfg_trig_en = 1'b0; cfg_wrap = 1'b0; cycles(3);
        wr(16'hA109, 8'h44, 1, 0, 0);
        wr(16'hA102, 8'h55, 1, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_post", 32'(post_code), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        wr(16'hA100, 8'h09, 1, 0, 0);
        chk("post_rst_level", 32'(level), 32'd1);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
